mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of master and slave ports.
REQ-002 Parameter DATA_W, default 32, data width; byte-enable width is DATA_W/8.
REQ-003 Parameter MAX_HOLD, default 16, maximum consecutive locked grants to master 1 (range 1..255).
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 m0_req  in  1  master 0 (CPU data port) access request.
REQ-008 m0_wen  in  DATA_W/8  byte write enables; all-zero means read.
REQ-009 m0_addr / m0_wdata  in  ADDR_W / DATA_W  master 0 address and write data.
REQ-010 m0_gnt  out  1  access accepted this cycle.
REQ-011 m0_rvalid / m0_rdata  out  1 / DATA_W  read data return for master 0.
REQ-012 m1_req, m1_wen, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as master 0, for master 1 (loader/debug port).
REQ-013 m1_lock  in  1  master 1 requests to keep its grant on following cycles.
REQ-014 s_en / s_wen / s_addr / s_wdata  out  1 / DATA_W/8 / ADDR_W / DATA_W  shared slave (bridge data port) access.
REQ-015 s_rdata  in  DATA_W  slave read data, valid exactly one cycle after an s_en read.

Function
REQ-016 Grant is decided combinationally each cycle from the registered state and the current requests; at most one of m0_gnt/m1_gnt is high.
REQ-017 A master's access completes in its grant cycle; the master holds req, wen, addr and wdata stable until it sees its gnt.
REQ-018 Granted cycle: s_en=1 and s_wen/s_addr/s_wdata equal the granted master's inputs; no grant: s_en=0 and s_wen, s_addr, s_wdata all 0.
REQ-019 Reads (wen all zero): the block registers the owner; next cycle the owner's rvalid=1 and its rdata equals s_rdata. Writes never raise rvalid.
REQ-020 When no rvalid is pending, mX_rdata is 0.
REQ-021 FSM state ARB: single requester is granted; both requesting grants the master not in last_gnt (round-robin); last_gnt updates on every grant.
REQ-022 ARB -> LOCK1 when m1 is granted with m1_lock=1; hold_cnt is loaded to 1.
REQ-023 LOCK1: m1_req=1 grants m1 regardless of m0_req, hold_cnt increments per m1 grant; no grant is given while m1_req=0 and m1_lock=1.
REQ-024 LOCK1 -> ARB when m1_lock=0, or when hold_cnt=MAX_HOLD and m0_req=1; in the latter case m0 is granted in that same cycle.
REQ-025 hold_cnt saturates at MAX_HOLD; it does not wrap.
REQ-026 Grants in consecutive cycles are allowed; back-to-back reads from different masters each return rvalid on the correct master.

Reset
REQ-027 While rst=0: state ARB, last_gnt=m1 (m0 wins first contention), hold_cnt=0, read-owner pending cleared.
REQ-028 While rst=0: m0_gnt, m1_gnt, s_en, m0_rvalid and m1_rvalid are 0; s_wen, s_addr, s_wdata, m0_rdata and m1_rdata are 0.
REQ-029 Reset asserted with a read in flight discards it; no rvalid follows reset release.

Verification
REQ-030 Only m0 reads addr 0x100 with s_rdata=0xDEADBEEF next cycle -> m0_gnt same cycle, m0_rvalid=1 with 0xDEADBEEF one cycle later, m1_rvalid=0.
REQ-031 First cycle after reset, m0 and m1 both request -> m0 granted, then m1 next cycle, alternating while both hold req.
REQ-032 m1 write with m1_lock=1 for 20 cycles, m0_req high, MAX_HOLD=16 -> 16 m1 grants, then m0 granted once, state returns to ARB.
REQ-033 m1 read grant followed by m0 read grant in the next cycle -> m1_rvalid then m0_rvalid on consecutive cycles, each with its own s_rdata.
REQ-034 rst driven low one cycle after an m0 read grant -> no m0_rvalid after release; all outputs 0 during reset.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Two-master / one-slave memory access bundle; "master" is the requester side, "slave" the arbiter.
// Carries both master request ports, their grant/read-return signals and the shared slave port.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  m0_req;
    logic [DATA_W/8-1:0]   m0_wen;
    logic [ADDR_W-1:0]     m0_addr;
    logic [DATA_W-1:0]     m0_wdata;
    logic                  m0_gnt;
    logic                  m0_rvalid;
    logic [DATA_W-1:0]     m0_rdata;

    logic                  m1_req;
    logic                  m1_lock;
    logic [DATA_W/8-1:0]   m1_wen;
    logic [ADDR_W-1:0]     m1_addr;
    logic [DATA_W-1:0]     m1_wdata;
    logic                  m1_gnt;
    logic                  m1_rvalid;
    logic [DATA_W-1:0]     m1_rdata;

    logic                  s_en;
    logic [DATA_W/8-1:0]   s_wen;
    logic [ADDR_W-1:0]     s_addr;
    logic [DATA_W-1:0]     s_wdata;
    logic [DATA_W-1:0]     s_rdata;

    modport master (
        output m0_req, m0_wen, m0_addr, m0_wdata,
        output m1_req, m1_lock, m1_wen, m1_addr, m1_wdata,
        output s_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  s_en, s_wen, s_addr, s_wdata
    );

    modport slave (
        input  m0_req, m0_wen, m0_addr, m0_wdata,
        input  m1_req, m1_lock, m1_wen, m1_addr, m1_wdata,
        input  s_rdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output s_en, s_wen, s_addr, s_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of two masters onto one slave, with a bounded lock for master 1; grant is same-cycle.
// Read data returns one cycle after the grant; losers are backpressured by holding req until gnt.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int            BE_W     = DATA_W / 8;
    localparam logic [7:0]    HOLD_MAX = 8'(MAX_HOLD);

    typedef enum logic {ARB, LOCK1} state_t;

    state_t        state;
    logic          last_m1;
    logic [7:0]    hold_cnt;
    logic          rd_pend;
    logic          rd_m1;
    logic          gnt0;
    logic          gnt1;
    logic          is_read;

    // Grants are forced low while reset is asserted, even with requests present.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst) begin
            if (state == LOCK1 && bus.m1_lock) begin
                if (hold_cnt == HOLD_MAX && bus.m0_req) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = bus.m1_req;
                end
            end else if (bus.m0_req && bus.m1_req) begin
                gnt0 = last_m1;
                gnt1 = !last_m1;
            end else begin
                gnt0 = bus.m0_req;
                gnt1 = bus.m1_req;
            end
        end
    end

    assign is_read = gnt0 ? (bus.m0_wen == '0) : (gnt1 && (bus.m1_wen == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ARB;
            last_m1  <= 1'b1;
            hold_cnt <= '0;
            rd_pend  <= 1'b0;
            rd_m1    <= 1'b0;
        end else begin
            if (gnt0 || gnt1) begin
                last_m1 <= gnt1;
            end
            rd_pend <= is_read;
            rd_m1   <= gnt1;
            if (gnt1 && bus.m1_lock) begin
                state <= LOCK1;
                if (state == ARB) begin
                    hold_cnt <= 8'd1;
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_cnt <= hold_cnt + 8'd1;
                end
            end else if (gnt0 || !bus.m1_lock) begin
                state    <= ARB;
                hold_cnt <= '0;
            end
        end
    end

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.s_en      = gnt0 | gnt1;
    assign bus.s_wen     = gnt0 ? bus.m0_wen   : (gnt1 ? bus.m1_wen   : {BE_W{1'b0}});
    assign bus.s_addr    = gnt0 ? bus.m0_addr  : (gnt1 ? bus.m1_addr  : {ADDR_W{1'b0}});
    assign bus.s_wdata   = gnt0 ? bus.m0_wdata : (gnt1 ? bus.m1_wdata : {DATA_W{1'b0}});

    assign bus.m0_rvalid = rd_pend && !rd_m1;
    assign bus.m1_rvalid = rd_pend && rd_m1;
    assign bus.m0_rdata  = bus.m0_rvalid ? bus.s_rdata : {DATA_W{1'b0}};
    assign bus.m1_rdata  = bus.m1_rvalid ? bus.s_rdata : {DATA_W{1'b0}};
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle reference model plus hand-computed literal checks.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: lock flag, grant count under lock, last winner, pending read owner (-1 none).
    bit m_locked = 1'b0;
    int m_held   = 0;
    int m_last   = 1;
    int m_pend   = -1;

    always @(negedge clk) begin : scoreboard
        int          win;
        logic [3:0]  ew;
        logic [31:0] ea;
        logic [31:0] ed;
        if (!rst) begin
            chk("rst_m0_gnt", bus.m0_gnt, 0);
            chk("rst_m1_gnt", bus.m1_gnt, 0);
            chk("rst_s_en", bus.s_en, 0);
            chk("rst_s_wen", bus.s_wen, 0);
            chk("rst_s_addr", bus.s_addr, 0);
            chk("rst_s_wdata", bus.s_wdata, 0);
            chk("rst_m0_rvalid", bus.m0_rvalid, 0);
            chk("rst_m1_rvalid", bus.m1_rvalid, 0);
            chk("rst_m0_rdata", bus.m0_rdata, 0);
            chk("rst_m1_rdata", bus.m1_rdata, 0);
            m_locked = 1'b0;
            m_held   = 0;
            m_last   = 1;
            m_pend   = -1;
        end else begin
            win = -1;
            if (m_locked && bus.m1_lock) begin
                if (m_held == MH && bus.m0_req) win = 0;
                else if (bus.m1_req)           win = 1;
            end else if (bus.m0_req && bus.m1_req) begin
                win = (m_last == 1) ? 0 : 1;
            end else if (bus.m0_req) begin
                win = 0;
            end else if (bus.m1_req) begin
                win = 1;
            end
            ew = (win == 0) ? bus.m0_wen   : (win == 1) ? bus.m1_wen   : 4'h0;
            ea = (win == 0) ? bus.m0_addr  : (win == 1) ? bus.m1_addr  : 32'h0;
            ed = (win == 0) ? bus.m0_wdata : (win == 1) ? bus.m1_wdata : 32'h0;
            chk("m0_gnt", bus.m0_gnt, win == 0);
            chk("m1_gnt", bus.m1_gnt, win == 1);
            chk("s_en", bus.s_en, win >= 0);
            chk("s_wen", bus.s_wen, ew);
            chk("s_addr", bus.s_addr, ea);
            chk("s_wdata", bus.s_wdata, ed);
            chk("m0_rvalid", bus.m0_rvalid, m_pend == 0);
            chk("m1_rvalid", bus.m1_rvalid, m_pend == 1);
            chk("m0_rdata", bus.m0_rdata, (m_pend == 0) ? bus.s_rdata : 32'h0);
            chk("m1_rdata", bus.m1_rdata, (m_pend == 1) ? bus.s_rdata : 32'h0);
            if (win >= 0) m_last = win;
            if (win == 1 && bus.m1_lock) begin
                m_held   = m_locked ? ((m_held < MH) ? m_held + 1 : MH) : 1;
                m_locked = 1'b1;
            end else if (win == 0 || !bus.m1_lock) begin
                m_locked = 1'b0;
                m_held   = 0;
            end
            m_pend = (win >= 0 && ew == 4'h0) ? win : -1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.m0_req = 1'b0; bus.m0_wen = '0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_lock = 1'b0; bus.m1_wen = '0; bus.m1_addr = '0; bus.m1_wdata = '0;
    endtask

    task automatic set_m0(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
        bus.m0_req = 1'b1; bus.m0_wen = wen; bus.m0_addr = addr; bus.m0_wdata = wdata;
    endtask

    task automatic set_m1(input logic lock, input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata);
        bus.m1_req = 1'b1; bus.m1_lock = lock; bus.m1_wen = wen; bus.m1_addr = addr; bus.m1_wdata = wdata;
    endtask

    int m0_cnt, m1_before, m1_after, m0_at;
    bit m0_done;

    initial begin
        idle();
        bus.s_rdata = 32'h0;
        // Requests present during reset must not produce grants.
        set_m0(4'h0, 32'h55, 32'h0);
        set_m1(1'b1, 4'h0, 32'h66, 32'h0);
        repeat (3) begin
            @(negedge clk);
            chk("lit_rst_gnt", {bus.m0_gnt, bus.m1_gnt, bus.s_en}, 0);
        end
        step();
        rst = 1'b1;

        // Both masters read continuously: strict alternation starting with m0.
        idle();
        set_m0(4'h0, 32'h10, 32'h0);
        set_m1(1'b0, 4'h0, 32'h20, 32'h0);
        for (int k = 0; k < 4; k++) begin
            bus.s_rdata = 32'hA000_0000 + k;
            @(negedge clk);
            chk("lit_rr_m0_gnt", bus.m0_gnt, (k % 2) == 0);
            chk("lit_rr_m1_gnt", bus.m1_gnt, (k % 2) == 1);
            if (k >= 1) begin
                chk("lit_rr_m0_rvalid", bus.m0_rvalid, (k % 2) == 1);
                chk("lit_rr_rdata", bus.m0_rdata | bus.m1_rdata, 32'hA000_0000 + k);
            end
            step();
        end
        idle();
        bus.s_rdata = 32'hA000_0004;
        @(negedge clk);
        chk("lit_rr_last_m1_rvalid", bus.m1_rvalid, 1);
        step();

        // Single m0 read of 0x100.
        set_m0(4'h0, 32'h100, 32'h0);
        bus.s_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("lit_rd_m0_gnt", bus.m0_gnt, 1);
        chk("lit_rd_s_addr", bus.s_addr, 32'h100);
        step();
        idle();
        bus.s_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("lit_rd_m0_rvalid", bus.m0_rvalid, 1);
        chk("lit_rd_m0_rdata", bus.m0_rdata, 32'hDEAD_BEEF);
        chk("lit_rd_m1_rvalid", bus.m1_rvalid, 0);
        step();
        bus.s_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("lit_idle_m0_rdata", bus.m0_rdata, 0);
        step();

        // m1 read then m0 read back-to-back.
        set_m1(1'b0, 4'h0, 32'h200, 32'h0);
        @(negedge clk);
        chk("lit_b2b_m1_gnt", bus.m1_gnt, 1);
        step();
        idle();
        set_m0(4'h0, 32'h300, 32'h0);
        bus.s_rdata = 32'h1111_1111;
        @(negedge clk);
        chk("lit_b2b_m1_rdata", bus.m1_rdata, 32'h1111_1111);
        chk("lit_b2b_m0_rvalid_early", bus.m0_rvalid, 0);
        step();
        idle();
        bus.s_rdata = 32'h2222_2222;
        @(negedge clk);
        chk("lit_b2b_m0_rdata", bus.m0_rdata, 32'h2222_2222);
        chk("lit_b2b_m1_rvalid", bus.m1_rvalid, 0);
        step();

        // Write: forwarded to the slave, no read return.
        set_m0(4'b0011, 32'h400, 32'hA5A5_5A5A);
        @(negedge clk);
        chk("lit_wr_s_wen", bus.s_wen, 4'b0011);
        chk("lit_wr_s_wdata", bus.s_wdata, 32'hA5A5_5A5A);
        step();
        idle();
        @(negedge clk);
        chk("lit_wr_no_rvalid", bus.m0_rvalid, 0);
        step();

        // Reset lands on a read in flight: the return is discarded.
        set_m0(4'h0, 32'h500, 32'h0);
        @(negedge clk);
        chk("lit_rstrd_m0_gnt", bus.m0_gnt, 1);
        step();
        rst = 1'b0;
        bus.s_rdata = 32'hBAD0_BAD0;
        set_m1(1'b0, 4'h0, 32'h510, 32'h0);
        @(negedge clk);
        chk("lit_rstrd_m0_rvalid", bus.m0_rvalid, 0);
        chk("lit_rstrd_s_en", bus.s_en, 0);
        step();
        rst = 1'b1;
        idle();
        repeat (2) begin
            @(negedge clk);
            chk("lit_rstrd_after", {bus.m0_rvalid, bus.m1_rvalid}, 0);
            step();
        end

        // m1 locked writes with m0 waiting: 16 m1 grants, then m0 once, then round-robin again.
        m0_cnt = 0; m1_before = 0; m1_after = 0; m0_at = -1; m0_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            set_m1(1'b1, 4'hF, 32'h600, 32'h0BAD_F00D);
            if (i >= 1 && !m0_done) set_m0(4'h0, 32'h700, 32'h0);
            else begin bus.m0_req = 1'b0; bus.m0_addr = '0; end
            @(negedge clk);
            if (bus.m0_gnt) begin m0_cnt++; m0_at = i; m0_done = 1'b1; end
            else if (bus.m1_gnt && !m0_done) m1_before++;
            else if (bus.m1_gnt) m1_after++;
            step();
        end
        chk("lit_lock_m1_before", m1_before, 16);
        chk("lit_lock_m0_count", m0_cnt, 1);
        chk("lit_lock_m0_cycle", m0_at, 16);
        chk("lit_lock_m1_after", m1_after, 3);

        // Lock held with m1 idle: nobody is granted, m0 waits.
        idle();
        set_m0(4'h0, 32'h800, 32'h0);
        bus.m1_lock = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("lit_lockidle_gnt", {bus.m0_gnt, bus.m1_gnt}, 0);
            step();
        end
        bus.m1_lock = 1'b0;
        @(negedge clk);
        step();
        idle();
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
